// File: rtl/spare_remap_ctrl_pkg.sv
// Shared sizing and payload types for the spare-macro remap controller.
package spare_remap_ctrl_pkg;

    localparam int unsigned NSPARE = 25;
    localparam int unsigned BANK_W = 5;
    localparam int unsigned ROW_W  = 7;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned DATA_W = 8;

    // Command presented to the spare array in the issue cycle.
    typedef struct packed {
        logic              web;
        logic [ROW_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } spare_cmd_t;

endpackage

// File: rtl/spare_cam_match.sv
// Parallel bank compare over the remap table with lowest-index priority,
// plus duplicate detection for an incoming fault report.
module spare_cam_match #(
    parameter int unsigned NSPARE = 25,
    parameter int unsigned BANK_W = 5,
    parameter int unsigned SEL_W  = 5
) (
    input  logic [NSPARE-1:0]             entry_valid,
    input  logic [NSPARE-1:0][BANK_W-1:0] entry_bank,
    input  logic [BANK_W-1:0]             lookup_bank,
    input  logic [BANK_W-1:0]             fault_bank,
    output logic                          hit_c,
    output logic [SEL_W-1:0]              hit_idx_c,
    output logic                          dup_c
);

    // Walk from the top index down so the lowest match is the last assignment.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        dup_c     = 1'b0;
        for (int i = int'(NSPARE) - 1; i >= 0; i--) begin
            if (entry_valid[i] && (entry_bank[i] == lookup_bank)) begin
                hit_c     = 1'b1;
                hit_idx_c = SEL_W'(i);
            end
            if (entry_valid[i] && (entry_bank[i] == fault_bank)) begin
                dup_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spare_remap_ctrl.sv
// Redirects accesses to faulty main-memory banks onto spare 128x8 macros,
// allocating spares in order as the BIST reports faults.
module spare_remap_ctrl #(
    parameter int unsigned NSPARE = spare_remap_ctrl_pkg::NSPARE,
    parameter int unsigned BANK_W = spare_remap_ctrl_pkg::BANK_W
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      fault_valid,
    input  logic [BANK_W-1:0]                         fault_bank,
    input  logic                                      tbl_clr,
    input  logic                                      req_valid,
    input  logic                                      req_web,
    input  logic [BANK_W+spare_remap_ctrl_pkg::ROW_W-1:0] req_addr,
    input  logic [spare_remap_ctrl_pkg::DATA_W-1:0]   req_wdata,
    output logic [spare_remap_ctrl_pkg::ROW_W-1:0]    mem_addr,
    output logic                                      mem_ce,
    output logic                                      mem_web,
    output logic [NSPARE-1:0]                         mem_csb,
    output logic [NSPARE-1:0]                         mem_oeb,
    output logic [spare_remap_ctrl_pkg::DATA_W-1:0]   mem_idata,
    output logic [spare_remap_ctrl_pkg::SEL_W-1:0]    mem_odata_select,
    output logic                                      remap_hit,
    output logic                                      rd_valid,
    output logic                                      full,
    output logic                                      overflow,
    output logic [spare_remap_ctrl_pkg::SEL_W-1:0]    used_cnt
);

    import spare_remap_ctrl_pkg::*;

    logic [NSPARE-1:0]             entry_valid;
    logic [NSPARE-1:0][BANK_W-1:0] entry_bank;
    logic [SEL_W-1:0]              cnt_q;
    logic                          ovf_q;
    logic                          hit_c;
    logic                          dup_c;
    logic [SEL_W-1:0]              hit_idx_c;
    logic                          full_c;
    logic                          issue_c;
    spare_cmd_t                    cmd_q;
    logic                          rd_q;
    logic [SEL_W-1:0]              rd_idx_q;

    assign full_c  = (cnt_q == SEL_W'(NSPARE));
    assign issue_c = req_valid && hit_c;

    spare_cam_match #(
        .NSPARE (NSPARE),
        .BANK_W (BANK_W),
        .SEL_W  (SEL_W)
    ) u_cam (
        .entry_valid (entry_valid),
        .entry_bank  (entry_bank),
        .lookup_bank (req_addr[BANK_W+ROW_W-1:ROW_W]),
        .fault_bank  (fault_bank),
        .hit_c       (hit_c),
        .hit_idx_c   (hit_idx_c),
        .dup_c       (dup_c)
    );

    // Remap table: clear wins over a fault; new banks fill the next free slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            entry_valid <= '0;
            entry_bank  <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (tbl_clr) begin
            entry_valid <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (fault_valid && !dup_c) begin
            if (full_c) begin
                ovf_q <= 1'b1;
            end else begin
                for (int i = 0; i < int'(NSPARE); i++) begin
                    if (SEL_W'(i) == cnt_q) begin
                        entry_valid[i] <= 1'b1;
                        entry_bank[i]  <= fault_bank;
                    end
                end
                cnt_q <= cnt_q + SEL_W'(1);
            end
        end
    end

    // Issue stage: one registered cycle from request to spare-array strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_ce    <= 1'b0;
            mem_csb   <= '1;
            cmd_q     <= '{web: 1'b1, addr: '0, data: '0};
            remap_hit <= 1'b0;
            rd_q      <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            mem_ce    <= issue_c;
            remap_hit <= issue_c;
            rd_q      <= issue_c && req_web;
            if (issue_c) begin
                mem_csb  <= ~(NSPARE'(1) << hit_idx_c);
                cmd_q    <= '{web: req_web, addr: req_addr[ROW_W-1:0], data: req_wdata};
                rd_idx_q <= hit_idx_c;
            end else begin
                mem_csb   <= '1;
                cmd_q.web <= 1'b1;
            end
        end
    end

    // Read-data stage: output enable and mux select follow a read issue by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid         <= 1'b0;
            mem_oeb          <= '1;
            mem_odata_select <= '0;
        end else begin
            rd_valid <= rd_q;
            if (rd_q) begin
                mem_oeb          <= ~(NSPARE'(1) << rd_idx_q);
                mem_odata_select <= rd_idx_q;
            end else begin
                mem_oeb <= '1;
            end
        end
    end

    assign mem_web   = cmd_q.web;
    assign mem_addr  = cmd_q.addr;
    assign mem_idata = cmd_q.data;
    assign full      = full_c;
    assign overflow  = ovf_q;
    assign used_cnt  = cnt_q;

endmodule
